wb_drain_ctrl: RTL and testbench

- Downstream consumer of the cache's 4-entry eviction write buffer.
- Pops one buffered dirty line at a time: 27-bit line address plus 256-bit data.
- Writes the line to main memory as a burst of 32-bit beats over a req/ready handshake.
- Exposes an in-flight address compare so read-miss logic can stall on a line that is being drained.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/wb_drain_ctrl.sv | 86 ++++++++
 tb/tb_wb_drain_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and types for the eviction write-buffer drain path
package cache_pkg;

    localparam int LINE_ADDR_W = 27;
    localparam int LINE_W      = 256;
    localparam int WORD_W      = 32;
    localparam int BEATS       = LINE_W / WORD_W;
    localparam int OFFSET_W    = 5;
    localparam int BEAT_W      = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    typedef logic [BEAT_W-1:0] beat_t;

    // Byte address of one beat: line address, beat index, then word-aligned zero bits.
    function automatic logic [LINE_ADDR_W+OFFSET_W-1:0] beat_byte_addr(
        input logic [LINE_ADDR_W-1:0] line_addr,
        input beat_t                  beat
    );
        return {line_addr, beat, {(OFFSET_W-BEAT_W){1'b0}}};
    endfunction

endpackage

// File: rtl/wb_drain_ctrl.sv
// rtl/wb_drain_ctrl.sv - pops dirty lines from the write buffer and bursts them to memory
module wb_drain_ctrl
    import cache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [LINE_ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0]      wb_data,
    output logic                   wb_pop,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [WORD_W-1:0]      mem_wdata,
    input  logic                   mem_ready,
    input  logic [LINE_ADDR_W-1:0] chk_addr,
    output logic                   chk_hit,
    output logic                   busy,
    output logic                   line_done
);

    drain_state_t           state_q, state_d;
    beat_t                  beat_q, beat_d;
    logic [LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0]      line_data_q, line_data_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        wb_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                // The pop is the only point where the head entry is captured.
                wb_pop = wb_valid && !reset;
                if (wb_valid) begin
                    line_addr_d = wb_addr;
                    line_data_d = wb_data;
                    beat_d      = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == beat_t'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req   = (state_q == BURST);
        mem_we    = mem_req;
        busy      = (state_q != IDLE);
        line_done = (state_q == DONE);
        chk_hit   = busy && (chk_addr == line_addr_q);
        mem_addr  = beat_byte_addr(line_addr_q, beat_q);
        mem_wdata = line_data_q[beat_q*WORD_W +: WORD_W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
        end
    end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// tb/tb_wb_drain_ctrl.sv - scoreboard bench for wb_drain_ctrl
module tb_wb_drain_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         wb_valid = 1'b0;
    logic [26:0]  wb_addr = '0;
    logic [255:0] wb_data = '0;
    logic         wb_pop;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready = 1'b1;
    logic [26:0]  chk_addr = '0;
    logic         chk_hit;
    logic         busy;
    logic         line_done;

    wb_drain_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_pop    (wb_pop),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .busy      (busy),
        .line_done (line_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [26:0]  addr;
        logic [255:0] data;
    } entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_exp_t;

    entry_t      wb_q[$];
    beat_exp_t   exp_beats[$];
    logic [26:0] exp_pops[$];
    int          pop_cycles[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accepted = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic push_line(input logic [26:0] addr, input logic [31:0] base);
        entry_t e;
        beat_exp_t b;
        e.addr = addr;
        e.data = make_line(base);
        wb_q.push_back(e);
        exp_pops.push_back(addr);
        for (int i = 0; i < 8; i++) begin
            b.addr = {addr, 5'(i * 4)};
            b.data = base + 32'(i);
            exp_beats.push_back(b);
        end
    endtask

    // Write buffer model: head advances on the edge where wb_pop was seen.
    initial begin
        logic p;
        entry_t e;
        forever begin
            @(negedge clock);
            p = wb_pop;
            @(posedge clock);
            #1;
            if (p && wb_q.size() > 0) e = wb_q.pop_front();
            wb_valid = (wb_q.size() > 0);
            if (wb_q.size() > 0) begin
                wb_addr = wb_q[0].addr;
                wb_data = wb_q[0].data;
            end
        end
    end

    // Monitor: compares every accepted beat, pop and line_done against the scoreboard.
    initial begin
        logic prev_b7;
        beat_exp_t b;
        logic [26:0] pa;
        prev_b7 = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_b7 = 1'b0;
            end else begin
                if (prev_b7) check("line_done_after_beat7", line_done, 1'b1);
                else if (line_done) check("line_done_spurious", line_done, 1'b0);
                prev_b7 = 1'b0;
                if (!busy) check("chk_hit_idle", chk_hit, 1'b0);
                if (mem_req) begin
                    check("mem_we_eq_req", mem_we, 1'b1);
                    check("busy_in_burst", busy, 1'b1);
                    if (mem_ready) begin
                        accepted++;
                        check("beat_expected", exp_beats.size() != 0, 1'b1);
                        if (exp_beats.size() != 0) begin
                            b = exp_beats.pop_front();
                            check("mem_addr", mem_addr, b.addr);
                            check("mem_wdata", mem_wdata, b.data);
                        end
                        prev_b7 = (mem_addr[4:2] == 3'd7);
                    end
                end
                if (wb_pop) begin
                    pop_cycles.push_back(cyc);
                    check("pop_expected", exp_pops.size() != 0, 1'b1);
                    if (exp_pops.size() != 0) begin
                        pa = exp_pops.pop_front();
                        check("pop_addr", wb_addr, pa);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        repeat (2) @(posedge clock);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || wb_q.size() != 0 || wb_pop) && n < max_cycles);
        if (n >= max_cycles) check({name, "_timeout"}, busy, 1'b0);
    endtask

    task automatic wait_beat_presented(input string name, input logic [31:0] addr, input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(mem_req && mem_addr == addr) && n < max_cycles);
        if (n >= max_cycles) check({name, "_timeout"}, mem_addr, addr);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_wb_pop", wb_pop, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_line_done", line_done, 1'b0);
        check("rst_chk_hit", chk_hit, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Empty buffer for 20 cycles
        for (int i = 0; i < 20; i++) begin
            chk_addr = 27'(i * 3);
            @(negedge clock);
            check("empty_wb_pop", wb_pop, 1'b0);
            check("empty_mem_req", mem_req, 1'b0);
            check("empty_busy", busy, 1'b0);
            @(posedge clock);
            #1;
        end

        // Single line with chk_hit probing during the burst
        push_line(27'h000_0123, 32'h1000_0000);
        wait_beat_presented("single_first_beat", 32'h0000_2460, 20);
        @(posedge clock);
        #1;
        chk_addr = 27'h000_0123;
        @(negedge clock);
        check("chk_hit_match", chk_hit, 1'b1);
        @(posedge clock);
        #1;
        chk_addr = 27'h000_0124;
        @(negedge clock);
        check("chk_hit_other", chk_hit, 1'b0);
        wait_idle("single", 100);
        chk_addr = 27'h000_0123;
        @(negedge clock);
        check("chk_hit_idle_same_addr", chk_hit, 1'b0);
        check("single_beats_drained", exp_beats.size(), 0);

        // Backpressure: hold beat 2 for three cycles
        push_line(27'h000_0123, 32'h1000_0000);
        wait_beat_presented("bp_beat1", 32'h0000_2464, 30);
        @(posedge clock);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold_addr", mem_addr, 32'h0000_2468);
            check("bp_hold_wdata", mem_wdata, 32'h1000_0002);
            check("bp_hold_req", mem_req, 1'b1);
            @(posedge clock);
            #1;
        end
        mem_ready = 1'b1;
        wait_idle("bp", 100);
        check("bp_beats_drained", exp_beats.size(), 0);

        // Four back-to-back lines
        pop_cycles.delete();
        accepted = 0;
        push_line(27'h000_0200, 32'hA000_0000);
        push_line(27'h000_0201, 32'hB000_0000);
        push_line(27'h7FF_FFFF, 32'hC000_0000);
        push_line(27'h000_0000, 32'hD000_0000);
        wait_idle("b2b", 300);
        check("b2b_pop_count", pop_cycles.size(), 4);
        check("b2b_beat_count", accepted, 32);
        for (int i = 1; i < pop_cycles.size(); i++)
            check("b2b_pop_gap", pop_cycles[i] - pop_cycles[i-1], 10);
        check("b2b_beats_drained", exp_beats.size(), 0);

        // Reset while beat 4 is presented
        push_line(27'h000_0345, 32'h5500_0000);
        wait_beat_presented("rst_beat3", {27'h000_0345, 5'h0C}, 30);
        @(posedge clock);
        #1;
        check("rst_at_beat4_addr", mem_addr, {27'h000_0345, 5'h10});
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_line_done", line_done, 1'b0);
        check("midrst_wb_pop", wb_pop, 1'b0);
        exp_beats.delete();
        reset = 1'b0;
        mem_ready = 1'b1;
        push_line(27'h000_0456, 32'h6600_0000);
        wait_beat_presented("restart_beat0", {27'h000_0456, 5'h00}, 20);
        wait_idle("restart", 100);
        check("restart_beats_drained", exp_beats.size(), 0);
        check("all_pops_seen", exp_pops.size(), 0);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1);
    end

endmodule
